sprite_scheduler: RTL and testbench

- Double-buffered sprite list between the sprite producer (singleprocessor) and the graphics sprite-ingest port. Both sides run on clk_pixel.
- The producer writes sprite entries at any time during a video frame into the write bank.
- On new_frame the banks swap. The previous frame's list is then streamed to graphics over a valid/ready handshake, so graphics sees a complete, consistent list once per frame.
- Drops, overflow and late-frame events are counted for debug on the seven-segment display.

---
 rtl/sprite_scheduler.sv | 112 +++++++++++
 tb/tb_sprite_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
// Double-buffered sprite list: producer fills one bank while the other streams to graphics.
// First entry valid 2 cycles after new_frame, one entry per 2 cycles; stream stalls on !sprite_ready.
module sprite_scheduler #(
  parameter int CANVAS_WIDTH  = 360,
  parameter int CANVAS_HEIGHT = 720,
  parameter int NUM_FRAMES    = 24,
  parameter int MAX_SPRITES   = 64
) (
  input  logic                          clk_pixel,
  input  logic                          sys_rst,
  input  logic                          new_frame,
  input  logic                          wr_valid,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]  wr_x,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0] wr_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]    wr_frame,
  output logic                          wr_ready,
  output logic                          sprite_valid,
  output logic [$clog2(CANVAS_WIDTH)-1:0]  sprite_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0] sprite_y,
  output logic [$clog2(NUM_FRAMES)-1:0]    sprite_frame_number,
  input  logic                          sprite_ready,
  output logic [7:0]                    drop_count,
  output logic [7:0]                    late_count
);

  localparam int XW = $clog2(CANVAS_WIDTH);
  localparam int YW = $clog2(CANVAS_HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int AW = $clog2(MAX_SPRITES);
  localparam int CW = AW + 1;
  localparam int DW = XW + YW + FW;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_wr_bank;
  logic [CW-1:0]   r_wr_count;
  logic [CW-1:0]   r_rd_count;
  logic [CW-1:0]   r_rd_idx;
  logic [7:0]      r_drop_count;
  logic [7:0]      r_late_count;
  logic [DW-1:0]   r_mem [2*MAX_SPRITES];
  logic [DW-1:0]   r_rd_dat;

  logic            w_in_range;
  logic            w_wr_acc;
  logic            w_last;
  logic            w_hs;
  logic [CW-1:0]   w_swap_count;

  assign w_in_range   = (wr_x < XW'(CANVAS_WIDTH)) && (wr_y < YW'(CANVAS_HEIGHT)) &&
                        (wr_frame < FW'(NUM_FRAMES));
  assign wr_ready     = (r_wr_count < CW'(MAX_SPRITES));
  assign w_wr_acc     = wr_valid && wr_ready && w_in_range;
  // A write landing on the swap cycle still belongs to the outgoing bank.
  assign w_swap_count = r_wr_count + CW'(w_wr_acc);
  assign w_last       = ((r_rd_idx + CW'(1)) == r_rd_count);
  assign w_hs         = (r_state == PRESENT) && sprite_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = IDLE;
      FETCH:   w_state_nxt = PRESENT;
      PRESENT: if (sprite_ready) w_state_nxt = w_last ? IDLE : FETCH;
      default: w_state_nxt = IDLE;
    endcase
    if (new_frame) w_state_nxt = (w_swap_count != '0) ? FETCH : IDLE;
  end

  always_ff @(posedge clk_pixel) begin
    if (w_wr_acc) r_mem[{r_wr_bank, r_wr_count[AW-1:0]}] <= {wr_x, wr_y, wr_frame};
  end

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_wr_bank    <= 1'b0;
      r_wr_count   <= '0;
      r_rd_count   <= '0;
      r_rd_idx     <= '0;
      r_drop_count <= '0;
      r_late_count <= '0;
      r_rd_dat     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (wr_valid && !w_wr_acc && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
      if (r_state == FETCH)
        r_rd_dat <= r_mem[{~r_wr_bank, r_rd_idx[AW-1:0]}];
      if (new_frame) begin
        // Any unfinished stream is abandoned in favour of the fresh list.
        r_wr_bank  <= ~r_wr_bank;
        r_rd_count <= w_swap_count;
        r_wr_count <= '0;
        r_rd_idx   <= '0;
        if ((r_state != IDLE) && (r_late_count != 8'hFF))
          r_late_count <= r_late_count + 8'd1;
      end else begin
        if (w_wr_acc) r_wr_count <= r_wr_count + CW'(1);
        if (w_hs && !w_last) r_rd_idx <= r_rd_idx + CW'(1);
      end
    end
  end

  assign sprite_valid = (r_state == PRESENT);
  assign {sprite_x, sprite_y, sprite_frame_number} = r_rd_dat;
  assign drop_count = r_drop_count;
  assign late_count = r_late_count;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: expected stream entries are queued by the stimulus
// and popped by a monitor on each handshake; scalar outputs are checked inline.
module tb_sprite_scheduler;

  typedef struct packed {
    logic [8:0] x;
    logic [9:0] y;
    logic [4:0] f;
  } ent_t;

  logic       clk_pixel = 1'b0;
  logic       sys_rst = 1'b1;
  logic       new_frame = 1'b0;
  logic       wr_valid = 1'b0;
  logic [8:0] wr_x = '0;
  logic [9:0] wr_y = '0;
  logic [4:0] wr_frame = '0;
  logic       wr_ready;
  logic       sprite_valid;
  logic [8:0] sprite_x;
  logic [9:0] sprite_y;
  logic [4:0] sprite_frame_number;
  logic       sprite_ready = 1'b0;
  logic [7:0] drop_count;
  logic [7:0] late_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t q[$];

  sprite_scheduler dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst), .new_frame(new_frame),
    .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_frame(wr_frame),
    .wr_ready(wr_ready), .sprite_valid(sprite_valid), .sprite_x(sprite_x),
    .sprite_y(sprite_y), .sprite_frame_number(sprite_frame_number),
    .sprite_ready(sprite_ready), .drop_count(drop_count), .late_count(late_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every accepted entry must match the head of the expected queue.
  always @(negedge clk_pixel) begin
    if (!sys_rst && sprite_valid && sprite_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_entry: got (%0d,%0d,%0d) required no entry",
                 sprite_x, sprite_y, sprite_frame_number);
      end else begin
        ent_t e;
        e = q.pop_front();
        if ({sprite_x, sprite_y, sprite_frame_number} !== e) begin
          n_bad++;
          $display("FAIL stream_entry: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   sprite_x, sprite_y, sprite_frame_number, e.x, e.y, e.f);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int x, input int y, input int f);
    wr_valid = 1'b1;
    wr_x = 9'(x);
    wr_y = 10'(y);
    wr_frame = 5'(f);
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic expect_ent(input int x, input int y, input int f);
    ent_t e;
    e.x = 9'(x);
    e.y = 10'(y);
    e.f = 5'(f);
    q.push_back(e);
  endtask

  task automatic pulse_frame();
    new_frame = 1'b1;
    cyc();
    new_frame = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || sprite_valid) && n < 400) begin
      cyc();
      n++;
    end
    chk({name, "_left"}, q.size(), 0);
    cyc();
    chk({name, "_idle"}, sprite_valid, 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cyc();
      chk(name, sprite_valid, 0);
    end
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    sys_rst = 1'b0;
    chk("rst_valid", sprite_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_drop", drop_count, 0);
    chk("rst_late", late_count, 0);
    chk("rst_out", {sprite_x, sprite_y, sprite_frame_number}, 0);

    // Three entries, ready high: valid at swap+2, entries every 2 cycles
    wr(10, 20, 1); wr(30, 40, 2); wr(359, 719, 23);
    expect_ent(10, 20, 1); expect_ent(30, 40, 2); expect_ent(359, 719, 23);
    sprite_ready = 1'b1;
    pulse_frame();
    chk("t1_fetch", sprite_valid, 0);
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("t1_pattern", sprite_valid, (k % 2 == 0 && k < 5) ? 1 : 0);
    end
    chk("t1_left", q.size(), 0);
    chk("t1_drop", drop_count, 0);

    // Stall for 10 cycles in PRESENT
    sprite_ready = 1'b0;
    wr(10, 20, 1); wr(30, 40, 2);
    expect_ent(10, 20, 1); expect_ent(30, 40, 2);
    pulse_frame();
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("t2_stall", {sprite_valid, sprite_x, sprite_y, sprite_frame_number},
          {1'b1, 9'd10, 10'd20, 5'd1});
      cyc();
    end
    sprite_ready = 1'b1;
    wait_drain("t2");

    // Overflow: 66 writes, 64 kept
    for (int i = 0; i < 66; i++) begin
      wr(i * 5, i * 11, i % 24);
      if (i < 64) expect_ent(i * 5, i * 11, i % 24);
      if (i == 62) chk("t3_ready_63", wr_ready, 1);
      if (i == 63) chk("t3_ready_64", wr_ready, 0);
    end
    chk("t3_drop_full", drop_count, 2);
    pulse_frame();
    chk("t3_ready_after_swap", wr_ready, 1);
    wr(360, 1, 1); wr(1, 720, 1); wr(1, 1, 24); wr(5, 6, 7);
    chk("t3_drop_range", drop_count, 5);
    wait_drain("t3_full");
    expect_ent(5, 6, 7);
    pulse_frame();
    wait_drain("t3_range");

    // Late frame: stream of 5 cut off by the next new_frame
    sprite_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(i, i, i);
    pulse_frame();
    cyc(); cyc();
    chk("t4_presenting", sprite_valid, 1);
    pulse_frame();
    chk("t4_valid_drop", sprite_valid, 0);
    chk("t4_late", late_count, 1);
    sprite_ready = 1'b1;
    quiet("t4_idle", 3);
    pulse_frame();
    quiet("t4_empty_frame", 4);
    chk("t4_late_hold", late_count, 1);

    // Write coinciding with new_frame joins the outgoing bank
    wr(1, 2, 3);
    expect_ent(1, 2, 3); expect_ent(4, 5, 6);
    wr_valid = 1'b1; wr_x = 9'd4; wr_y = 10'd5; wr_frame = 5'd6;
    new_frame = 1'b1;
    cyc();
    wr_valid = 1'b0; new_frame = 1'b0;
    wait_drain("t5");
    pulse_frame();
    quiet("t5_next_empty", 4);

    // Reset mid-stream
    sprite_ready = 1'b0;
    wr(7, 8, 9); wr(11, 12, 13); wr(14, 15, 16);
    pulse_frame();
    cyc();
    wr(17, 18, 19);
    chk("t6_presenting", sprite_valid, 1);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("t6_valid", sprite_valid, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_drop", drop_count, 0);
    chk("t6_late", late_count, 0);
    chk("t6_out", {sprite_x, sprite_y, sprite_frame_number}, 0);
    sprite_ready = 1'b1;
    pulse_frame();
    quiet("t6_no_output", 4);
    chk("t6_q_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
